// File: rtl/mole_spawn_ctrl.sv
// mole_spawn_ctrl
//   Mole generator and hit detector for the whack-a-mole game. While enabled,
//   it alternates between a quiet GAP phase and an UP phase. In the UP phase
//   one of eight hole LEDs is lit at a pseudo-random position. Debounced
//   button pulses are classified as hit, wrong or miss, and each result is
//   sent downstream as a one-cycle pulse.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   enable           run enable (game FSM is in PLAYING)
//   difficulty_level 0=easy, 1=medium, 2/3=hard; latched on each phase entry
//   hit_btn          one-cycle button pulses, bit i = hole i
//   mole_leds        one-hot lit hole, or all zero
//   active_hole      index of the lit hole; holds its last value when dark
//   hit_pulse        correct hole pressed while the mole was up
//   miss_pulse       mole timed out without being hit
//   wrong_pulse      press on a hole that was not lit (GAP or UP)
module mole_spawn_ctrl #(
  parameter int          TICK_DIV  = 100000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] difficulty_level,
  input  logic [7:0] hit_btn,
  output logic [7:0] mole_leds,
  output logic [2:0] active_hole,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       wrong_pulse
);

  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, UP = 2'd2} state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc;
  logic [10:0]   ms_cnt;
  logic [10:0]   phase_ms;
  logic [15:0]   lfsr;
  logic [1:0]    diff_q;
  logic          tick, phase_done, hit_now, wrong_any;
  logic [2:0]    sel_hole;
  logic [7:0]    lit_mask;
  logic [7:0]    leds_d;
  logic [2:0]    hole_d;
  logic          hit_d, miss_d, wrong_d;

  // Phase length in ms for the current phase, from the latched difficulty.
  always_comb begin
    phase_ms = 11'd0;
    if (state == UP) begin
      case (diff_q)
        2'd0:    phase_ms = 11'd1200;
        2'd1:    phase_ms = 11'd800;
        default: phase_ms = 11'd500;
      endcase
    end else begin
      case (diff_q)
        2'd0:    phase_ms = 11'd300;
        2'd1:    phase_ms = 11'd200;
        default: phase_ms = 11'd150;
      endcase
    end
  end

  // The phase ends on the tick that completes its last millisecond, so a
  // phase of N ms lasts exactly N*TICK_DIV cycles from entry.
  assign tick       = (state != IDLE) && (presc == PRESC_LAST);
  assign phase_done = tick && (ms_cnt == phase_ms - 11'd1);

  // active_hole doubles as prev_hole: both are written with the same value on
  // every UP entry, and both reset to 0.
  assign lit_mask = 8'd1 << active_hole;
  assign hit_now  = (state == UP) && hit_btn[active_hole];
  assign sel_hole = (lfsr[2:0] == active_hole) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

  always_comb begin
    wrong_any = 1'b0;
    if (state == GAP)
      wrong_any = |hit_btn;
    else if (state == UP)
      wrong_any = |(hit_btn & ~lit_mask);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; dropping enable wins over everything else.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = GAP;
        GAP:     if (phase_done) next_state = UP;
        UP:      if (hit_now || phase_done) next_state = GAP;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic: computes the values the output registers take next cycle.
  // Priority in UP is hit, then timeout, then wrong press.
  always_comb begin
    leds_d  = mole_leds;
    hole_d  = active_hole;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    wrong_d = 1'b0;
    if (!enable) begin
      leds_d = 8'd0;
    end else begin
      case (state)
        IDLE: leds_d = 8'd0;
        GAP: begin
          wrong_d = wrong_any;
          if (phase_done) begin
            hole_d = sel_hole;
            leds_d = 8'd1 << sel_hole;
          end
        end
        UP: begin
          if (hit_now) begin
            hit_d  = 1'b1;
            leds_d = 8'd0;
          end else if (phase_done) begin
            miss_d = 1'b1;
            leds_d = 8'd0;
          end else begin
            wrong_d = wrong_any;
          end
        end
        default: leds_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mole_leds   <= 8'd0;
      active_hole <= 3'd0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      mole_leds   <= leds_d;
      active_hole <= hole_d;
      hit_pulse   <= hit_d;
      miss_pulse  <= miss_d;
      wrong_pulse <= wrong_d;
    end
  end

  // Timebase. The LFSR free-runs in every state. The prescaler and ms counter
  // restart on every state change so each phase is timed from its own entry.
  // Difficulty is captured only when entering GAP/UP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      presc  <= '0;
      ms_cnt <= 11'd0;
      diff_q <= 2'd0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (next_state != state) begin
        presc  <= '0;
        ms_cnt <= 11'd0;
        if (next_state != IDLE)
          diff_q <= difficulty_level;
      end else if (state == IDLE) begin
        presc  <= '0;
        ms_cnt <= 11'd0;
      end else if (tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 11'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mole_spawn_ctrl.sv
// tb_mole_spawn_ctrl
//   Scoreboard bench for mole_spawn_ctrl. A behavioural reference model,
//   evaluated on every clock edge, pushes each expected output event (LED
//   change or pulse, stamped with its cycle) into a queue. A monitor on the
//   falling edge pops and compares whenever the DUT shows an event. A small
//   prescaler (TICK=2) keeps long mole sequences within the cycle budget.
module tb_mole_spawn_ctrl;

  localparam int          TICK   = 2;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          M_IDLE = 0;
  localparam int          M_GAP  = 1;
  localparam int          M_UP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] difficulty_level = 2'd0;
  logic [7:0] hit_btn = 8'd0;
  logic [7:0] mole_leds;
  logic [2:0] active_hole;
  logic       hit_pulse, miss_pulse, wrong_pulse;

  typedef struct {
    int         stamp;
    logic [7:0] leds;
    logic [2:0] hole;
    logic       hit;
    logic       miss;
    logic       wrong;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // Reference model state
  int          cyc = 0;
  int          m_mode = M_IDLE;
  int          m_start = 0;
  logic [1:0]  m_diff = 2'd0;
  logic [2:0]  m_hole = 3'd0;
  logic [7:0]  m_leds = 8'd0;
  logic [15:0] m_lfsr = SEED;

  // Monitor state
  logic [7:0] prev_leds = 8'd0;
  logic [2:0] last_lit = 3'd0;

  mole_spawn_ctrl #(.TICK_DIV(TICK), .LFSR_SEED(SEED)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .difficulty_level (difficulty_level),
    .hit_btn          (hit_btn),
    .mole_leds        (mole_leds),
    .active_hole      (active_hole),
    .hit_pulse        (hit_pulse),
    .miss_pulse       (miss_pulse),
    .wrong_pulse      (wrong_pulse)
  );

  always #5 clk = ~clk;

  function automatic int up_ms(input logic [1:0] d);
    return (d == 2'd0) ? 1200 : (d == 2'd1) ? 800 : 500;
  endfunction

  function automatic int gap_ms(input logic [1:0] d);
    return (d == 2'd0) ? 300 : (d == 2'd1) ? 200 : 150;
  endfunction

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endfunction

  // Reference model: phases are timed as whole-ms durations measured from the
  // edge at which the phase became visible.
  always @(posedge clk) begin : ref_model
    int         nmode;
    logic [7:0] nleds;
    logic [2:0] nhole;
    logic [2:0] h;
    logic       ph, pm, pw;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_leds = 8'd0;
      m_hole = 3'd0;
      m_diff = 2'd0;
      m_lfsr = SEED;
    end else begin
      nmode = m_mode;
      nleds = m_leds;
      nhole = m_hole;
      ph = 1'b0;
      pm = 1'b0;
      pw = 1'b0;
      if (!enable) begin
        nmode = M_IDLE;
        nleds = 8'd0;
      end else if (m_mode == M_IDLE) begin
        nmode   = M_GAP;
        m_start = cyc;
        m_diff  = difficulty_level;
      end else if (m_mode == M_GAP) begin
        pw = (hit_btn != 8'd0);
        if (cyc - m_start == TICK * gap_ms(m_diff)) begin
          h = m_lfsr[2:0];
          if (h == m_hole) h = h + 3'd1;
          nhole   = h;
          nleds   = 8'd1 << h;
          nmode   = M_UP;
          m_start = cyc;
          m_diff  = difficulty_level;
        end
      end else begin
        if (hit_btn[m_hole])
          ph = 1'b1;
        else if (cyc - m_start == TICK * up_ms(m_diff))
          pm = 1'b1;
        else
          pw = (hit_btn != 8'd0);
        if (ph || pm) begin
          nleds   = 8'd0;
          nmode   = M_GAP;
          m_start = cyc;
          m_diff  = difficulty_level;
        end
      end
      if (ph || pm || pw || (nleds != m_leds))
        exp_q.push_back('{cyc, nleds, nhole, ph, pm, pw});
      m_mode = nmode;
      m_leds = nleds;
      m_hole = nhole;
      if (m_lfsr[0])
        m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else
        m_lfsr = m_lfsr >> 1;
    end
  end

  // Monitor: any pulse or LED change is a DUT event and must match the head
  // of the expected queue, including the cycle it appeared in.
  always @(negedge clk) begin : monitor
    ev_t  e;
    logic is_ev;
    if (!rst_n) begin
      prev_leds = 8'd0;
      last_lit  = 3'd0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        check_output("missed_event", exp_q[0].stamp, cyc);
        void'(exp_q.pop_front());
      end
      is_ev = hit_pulse | miss_pulse | wrong_pulse | (mole_leds != prev_leds);
      if (is_ev) begin
        check_output("event_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("event_cycle", e.stamp, cyc);
          check_output("event_value",
                       32'({mole_leds, active_hole, hit_pulse, miss_pulse, wrong_pulse}),
                       32'({e.leds, e.hole, e.hit, e.miss, e.wrong}));
        end
      end
      if (mole_leds != 8'd0 && prev_leds == 8'd0) begin
        check_output("hole_no_repeat", (active_hole != last_lit), 1);
        last_lit = active_hole;
      end
      prev_leds = mole_leds;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] mask);
    hit_btn = mask;
    step();
    hit_btn = 8'd0;
  endtask

  task automatic wait_mode(input int mode, input int budget, input string name);
    int n = 0;
    while (m_mode != mode && n < budget) begin
      step();
      n++;
    end
    if (m_mode != mode) check_output(name, m_mode, mode);
  endtask

  task automatic check_zero(input string name);
    check_output(name, 32'({mole_leds, active_hole, hit_pulse, miss_pulse, wrong_pulse}), 0);
  endtask

  // Random moles: random difficulty, scattered random presses, then either a
  // correct press (sometimes with extra bits) or an enable drop.
  task automatic apply_stimulus(input int n_moles);
    int         d, r;
    logic [7:0] extra;
    for (int i = 0; i < n_moles; i++) begin
      difficulty_level = (i % 20 == 0) ? 2'd1 : 2'($urandom_range(3, 2));
      wait_mode(M_UP, 1500, "rand_wait_up");
      d = $urandom_range(15, 0);
      for (int k = 0; k < d; k++) begin
        hit_btn = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
        if ($urandom_range(7, 0) == 0) difficulty_level = 2'($urandom_range(3, 0));
        step();
      end
      hit_btn = 8'd0;
      difficulty_level = 2'($urandom_range(3, 2));
      if (m_mode == M_UP) begin
        r = $urandom_range(9, 0);
        if (r == 0) begin
          enable = 1'b0;
          step();
          step();
          enable = 1'b1;
        end else begin
          extra = (r == 1) ? 8'($urandom_range(255, 0)) : 8'd0;
          press((8'd1 << m_hole) | extra);
        end
      end
      if ($urandom_range(3, 0) == 0) begin
        repeat (5) step();
        press(8'($urandom_range(255, 1)));
      end
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [2:0] wh;
    int         n;
    $display("[TB] start");

    // Reset, then a long idle stretch with enable low
    repeat (3) step();
    check_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (1000) begin
      hit_btn = ($urandom_range(15, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      step();
    end
    hit_btn = 8'd0;
    check_zero("idle_outputs");

    // Easy, no presses: full gap, full up time, then a miss
    difficulty_level = 2'd0;
    enable = 1'b1;
    wait_mode(M_UP, 700, "easy_wait_up");
    wait_mode(M_GAP, 2500, "easy_wait_miss");

    // Hard, correct press 100 cycles after the LED comes on
    difficulty_level = 2'd2;
    wait_mode(M_UP, 700, "hard_wait_up");
    repeat (100) step();
    press(8'd1 << m_hole);

    // Correct hole plus another bit: hit only
    wait_mode(M_UP, 700, "multi_wait_up");
    repeat (3) step();
    wh = m_hole + 3'd5;
    press((8'd1 << m_hole) | (8'd1 << wh));

    // Single wrong bit: wrong pulse, LED stays, up timer keeps running to a miss
    wait_mode(M_UP, 700, "wrong_wait_up");
    repeat (7) step();
    wh = m_hole + 3'd2;
    press(8'd1 << wh);
    wait_mode(M_GAP, 1200, "wrong_wait_miss");

    // Correct press on the exact timeout edge, then a press during GAP
    wait_mode(M_UP, 700, "edge_wait_up");
    n = 0;
    while (cyc != m_start + TICK * up_ms(m_diff) - 1 && n < 1200) begin
      step();
      n++;
    end
    if (m_mode != M_UP) check_output("edge_wait_timeout", m_mode, M_UP);
    press(8'd1 << m_hole);
    repeat (20) step();
    press(8'h10);

    // Drop enable mid-UP, then re-enable for a full gap
    wait_mode(M_UP, 700, "drop_wait_up");
    repeat (20) step();
    hit_btn = 8'd1 << m_hole;
    enable = 1'b0;
    step();
    hit_btn = 8'd0;
    repeat (5) step();
    enable = 1'b1;
    wait_mode(M_UP, 700, "reenable_wait_up");

    // Asynchronous reset mid-UP
    repeat (10) step();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    apply_stimulus(200);

    enable = 1'b0;
    repeat (5) step();
    @(negedge clk);
    #1 check_output("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
